// File: rtl/fetch_buffer_pkg.sv
// Shared definitions for the instruction-fetch buffer.
//   XLEN             : architectural word / address width
//   INST_BYTES       : bytes per instruction (fetch stride)
//   DEFAULT_RESET_PC : default first fetch address after reset
//   entry_t          : one queue entry, {pc, inst}
//   next_pc()        : sequential PC step, wraps modulo 2^XLEN
package fetch_buffer_pkg;

  localparam int XLEN       = 32;
  localparam int INST_BYTES = 4;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } entry_t;

  function automatic logic [XLEN-1:0] next_pc(input logic [XLEN-1:0] pc);
    return pc + XLEN'(INST_BYTES);
  endfunction

endpackage

// File: rtl/fetch_buffer_if.sv
// Handshake bundle around the fetch buffer.
//   imem_req_*  : fetch request channel (valid/ready) towards instruction memory
//   imem_rsp_*  : in-order response words from instruction memory
//   redirect_*  : flush-and-restart request from the control path
//   inst_*      : instruction channel (valid/ready) towards decode
// Modports: master = fetch buffer side, slave = memory/decode/control side.
interface fetch_buffer_if;
  import fetch_buffer_pkg::*;

  logic            imem_req_valid;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_req_ready;
  logic            imem_rsp_valid;
  logic [XLEN-1:0] imem_rsp_data;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            inst_valid;
  logic [XLEN-1:0] inst_data;
  logic [XLEN-1:0] inst_pc;
  logic            inst_ready;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready,
    input  imem_rsp_valid, imem_rsp_data,
    input  redirect_valid, redirect_pc,
    output inst_valid, inst_data, inst_pc,
    input  inst_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready,
    output imem_rsp_valid, imem_rsp_data,
    output redirect_valid, redirect_pc,
    input  inst_valid, inst_data, inst_pc,
    output inst_ready
  );

endinterface

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of DEPTH {pc, inst} entries for the fetch buffer.
//   clock, reset : clock, asynchronous active-high reset
//   push/wr_entry: write one entry at the tail
//   pop          : retire the head entry (ignored when empty)
//   flush        : empty the queue; takes priority over push/pop
//   head         : head entry, read combinationally from storage
//   count        : occupancy, 0..DEPTH
module fetch_fifo
  import fetch_buffer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  entry_t        wr_entry,
  output entry_t        head,
  output logic [CW-1:0] count
);

  localparam int AW = $clog2(DEPTH);

  entry_t          mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            pop_ok;

  assign pop_ok = pop && (count != '0);
  assign head   = mem[rd_ptr];

  // Storage is cleared on reset so the head reads as zero out of reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= wr_entry;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop_ok) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop_ok);
    end
  end

endmodule

// File: rtl/fetch_buffer.sv
// Decoupled instruction-fetch stage with a DEPTH-entry prefetch queue.
// Issues sequential fetch addresses, buffers in-order responses with their
// PC, and hands them to decode. A redirect flushes the queue, restarts fetch
// at the new PC and discards every response still in flight.
//   clock, reset : clock, asynchronous active-high reset
//   bus          : fetch_buffer_if.master (imem req/rsp, redirect, inst)
module fetch_buffer
  import fetch_buffer_pkg::*;
#(
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic           clock,
  input  logic           reset,
  fetch_buffer_if.master bus
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] rsp_pc;
  logic [XLEN-1:0] redirect_aligned;
  logic [CW-1:0]   count;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   outstanding_next;
  logic [CW-1:0]   drop_cnt;
  logic [CW:0]     credit_used;
  logic            req_valid;
  logic            req_fire;
  logic            rsp_fire;
  logic            redirect;
  logic            push;
  logic            pop;
  entry_t          head;
  entry_t          push_entry;

  // Every slot is either occupied or reserved by an outstanding request, so
  // a same-cycle pop only frees its credit once count has been updated.
  assign credit_used = {1'b0, count} + {1'b0, outstanding};
  assign req_valid   = !reset && (credit_used < (CW+1)'(DEPTH));
  assign req_fire    = req_valid && bus.imem_req_ready;
  assign rsp_fire    = bus.imem_rsp_valid;
  assign redirect    = bus.redirect_valid;

  assign redirect_aligned = bus.redirect_pc & ~XLEN'(INST_BYTES - 1);
  assign outstanding_next = outstanding + CW'(req_fire) - CW'(rsp_fire);

  // A response in the redirect cycle belongs to the old stream.
  assign push       = rsp_fire && (drop_cnt == '0) && !redirect;
  assign pop        = (count != '0) && bus.inst_ready;
  assign push_entry = '{pc: rsp_pc, inst: bus.imem_rsp_data};

  fetch_fifo #(
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clock    (clock),
    .reset    (reset),
    .push     (push),
    .pop      (pop),
    .flush    (redirect),
    .wr_entry (push_entry),
    .head     (head),
    .count    (count)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fetch_pc    <= RESET_PC;
      rsp_pc      <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      outstanding <= outstanding_next;
      if (redirect) begin
        // Everything still owed by memory after this edge is old-stream,
        // including a request accepted in this very cycle.
        fetch_pc <= redirect_aligned;
        rsp_pc   <= redirect_aligned;
        drop_cnt <= outstanding_next;
      end else begin
        if (req_fire) fetch_pc <= next_pc(fetch_pc);
        if (rsp_fire) begin
          if (drop_cnt != '0) drop_cnt <= drop_cnt - CW'(1);
          else                rsp_pc   <= next_pc(rsp_pc);
        end
      end
    end
  end

  assign bus.imem_req_valid = req_valid;
  assign bus.imem_req_addr  = fetch_pc;
  assign bus.inst_valid     = (count != '0);
  assign bus.inst_data      = head.inst;
  assign bus.inst_pc        = head.pc;

  rsp_without_request : assert property (
    @(posedge clock) disable iff (reset) bus.imem_rsp_valid |-> (outstanding != '0)
  );

endmodule

// File: tb/tb_fetch_buffer.sv
module tb_fetch_buffer;
  import fetch_buffer_pkg::*;

  logic clock;
  logic reset;

  fetch_buffer_if bus ();

  fetch_buffer #(
    .DEPTH    (4),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.master)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  function automatic logic [31:0] memfn(input logic [31:0] a);
    return (a * 32'h0001_0003) ^ 32'hA5A5_5A5A;
  endfunction

  // ---------------- instruction memory model ----------------
  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;

  pend_t pend[$];
  int    cyc = 0;
  int    lat = 1;

  always @(posedge clock) begin
    cyc++;
    if (reset) begin
      pend.delete();
    end else begin
      if (bus.imem_rsp_valid && pend.size() > 0) void'(pend.pop_front());
      if (bus.imem_req_valid && bus.imem_req_ready)
        pend.push_back('{addr: bus.imem_req_addr, due: cyc + lat});
    end
  end

  always @(negedge clock) begin
    if (!reset && pend.size() > 0 && pend[0].due <= cyc + 1) begin
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data  = memfn(pend[0].addr);
    end else begin
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = 32'h0;
    end
  end

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic do_reset(input int latency);
    @(negedge clock);
    reset              = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
    bus.inst_ready     = 1'b1;
    bus.imem_req_ready = 1'b1;
    lat                = latency;
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("reset req_valid",  {31'b0, bus.imem_req_valid}, 32'h0);
    chk("reset req_addr",   bus.imem_req_addr, 32'h0);
    chk("reset inst_valid", {31'b0, bus.inst_valid}, 32'h0);
    chk("reset inst_data",  bus.inst_data, 32'h0);
    chk("reset inst_pc",    bus.inst_pc, 32'h0);
    reset = 1'b0;
    #1;
  endtask

  task automatic chk_inst(input string name, input logic [31:0] pc);
    chk({name, " inst_valid"}, {31'b0, bus.inst_valid}, 32'h1);
    chk({name, " inst_pc"},    bus.inst_pc, pc);
    chk({name, " inst_data"},  bus.inst_data, memfn(pc));
  endtask

  task automatic chk_req(input string name, input logic [31:0] addr);
    chk({name, " req_valid"}, {31'b0, bus.imem_req_valid}, 32'h1);
    chk({name, " req_addr"},  bus.imem_req_addr, addr);
  endtask

  task automatic chk_no_inst(input string name);
    chk({name, " inst_valid"}, {31'b0, bus.inst_valid}, 32'h0);
  endtask

  // Redirect issued at cycle 4 of a latency-1 full-rate stream.
  task automatic redirect_case(input string name, input logic [31:0] target,
                               input logic [31:0] pc0, input logic [31:0] pc1);
    do_reset(1);
    repeat (4) step();
    #1;
    chk_inst({name, " pre"}, 32'h8);
    chk_req({name, " pre"}, 32'h10);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = target;
    step();
    bus.redirect_valid = 1'b0;
    #1;
    chk_req({name, " c5"}, pc0);
    chk_no_inst({name, " c5"});
    step();
    #1;
    chk_req({name, " c6"}, pc1);
    chk_no_inst({name, " c6"});
    step();
    #1;
    chk_inst({name, " c7"}, pc0);
    step();
    #1;
    chk_inst({name, " c8"}, pc1);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        inst_ready;
    logic        mem_ready;
    logic        exp_req_valid;
    logic [31:0] exp_req_addr;
    logic        exp_inst_valid;
    logic [31:0] exp_inst_pc;
  } vec_t;

  vec_t vecs[17];

  task automatic setv(input int i, input logic ir, input logic mr, input logic rv,
                      input logic [31:0] addr, input logic iv, input logic [31:0] pc);
    vecs[i] = '{inst_ready: ir, mem_ready: mr, exp_req_valid: rv,
                exp_req_addr: addr, exp_inst_valid: iv, exp_inst_pc: pc};
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset              = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
    bus.inst_ready     = 1'b0;
    bus.imem_req_ready = 1'b0;

    // Latency-1 stream, then a 5-cycle stall filling the queue, then drain.
    setv( 0, 1'b1, 1'b1, 1'b1, 32'h00, 1'b0, 32'h00);
    setv( 1, 1'b1, 1'b1, 1'b1, 32'h04, 1'b0, 32'h00);
    setv( 2, 1'b1, 1'b1, 1'b1, 32'h08, 1'b1, 32'h00);
    setv( 3, 1'b1, 1'b1, 1'b1, 32'h0C, 1'b1, 32'h04);
    setv( 4, 1'b1, 1'b1, 1'b1, 32'h10, 1'b1, 32'h08);
    setv( 5, 1'b1, 1'b1, 1'b1, 32'h14, 1'b1, 32'h0C);
    setv( 6, 1'b0, 1'b1, 1'b1, 32'h18, 1'b1, 32'h10);
    setv( 7, 1'b0, 1'b1, 1'b1, 32'h1C, 1'b1, 32'h10);
    setv( 8, 1'b0, 1'b1, 1'b0, 32'h20, 1'b1, 32'h10);
    setv( 9, 1'b0, 1'b1, 1'b0, 32'h20, 1'b1, 32'h10);
    setv(10, 1'b1, 1'b1, 1'b0, 32'h20, 1'b1, 32'h10);
    setv(11, 1'b1, 1'b1, 1'b1, 32'h20, 1'b1, 32'h14);
    setv(12, 1'b1, 1'b1, 1'b1, 32'h24, 1'b1, 32'h18);
    setv(13, 1'b1, 1'b1, 1'b1, 32'h28, 1'b1, 32'h1C);
    setv(14, 1'b1, 1'b1, 1'b1, 32'h2C, 1'b1, 32'h20);
    setv(15, 1'b1, 1'b1, 1'b1, 32'h30, 1'b1, 32'h24);
    setv(16, 1'b1, 1'b1, 1'b1, 32'h34, 1'b1, 32'h28);

    do_reset(1);
    for (int i = 0; i < 17; i++) begin
      bus.inst_ready     = vecs[i].inst_ready;
      bus.imem_req_ready = vecs[i].mem_ready;
      #1;
      chk($sformatf("vec%0d req_valid", i), {31'b0, bus.imem_req_valid},
          {31'b0, vecs[i].exp_req_valid});
      chk($sformatf("vec%0d req_addr", i), bus.imem_req_addr, vecs[i].exp_req_addr);
      chk($sformatf("vec%0d inst_valid", i), {31'b0, bus.inst_valid},
          {31'b0, vecs[i].exp_inst_valid});
      if (vecs[i].exp_inst_valid) begin
        chk($sformatf("vec%0d inst_pc", i), bus.inst_pc, vecs[i].exp_inst_pc);
        chk($sformatf("vec%0d inst_data", i), bus.inst_data, memfn(vecs[i].exp_inst_pc));
      end
      step();
    end

    // Mid-stream reset with a full queue.
    bus.inst_ready = 1'b0;
    repeat (5) step();
    #1;
    chk_inst("full", 32'h2C);
    chk("full req_valid", {31'b0, bus.imem_req_valid}, 32'h0);
    #2;
    reset = 1'b1;
    #1;
    chk("async reset inst_valid", {31'b0, bus.inst_valid}, 32'h0);
    chk("async reset req_valid",  {31'b0, bus.imem_req_valid}, 32'h0);
    chk("async reset inst_pc",    bus.inst_pc, 32'h0);
    do_reset(1);
    chk_req("restart c0", 32'h0);
    chk_no_inst("restart c0");
    step();
    step();
    #1;
    chk_inst("restart c2", 32'h0);

    // Latency 3: redirect to 0x100 with three old responses owed.
    do_reset(3);
    repeat (3) step();
    bus.imem_req_ready = 1'b0;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h100;
    #1;
    chk_req("lat3 c3", 32'hC);
    step();
    bus.redirect_valid = 1'b0;
    bus.imem_req_ready = 1'b1;
    #1;
    chk_req("lat3 c4", 32'h100);
    chk_no_inst("lat3 c4");
    for (int c = 5; c <= 7; c++) begin
      step();
      #1;
      chk_no_inst($sformatf("lat3 c%0d", c));
    end
    step();
    #1;
    chk_inst("lat3 c8", 32'h100);
    step();
    #1;
    chk_inst("lat3 c9", 32'h104);

    // Redirect colliding with a response and a request accept; unaligned target.
    redirect_case("redir203", 32'h0000_0203, 32'h0000_0200, 32'h0000_0204);

    // Redirect to the top of the address space: PC wraps to zero.
    redirect_case("wrap", 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0000_0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
